// File: rtl/bus_mmio_pkg.sv
// Shared MMIO register map, STAT bit positions and read-source select for bus_mmio_responder.
// Byte-lane merge helper used by the lane-enabled MMIO registers.
package bus_mmio_pkg;

    localparam logic [15:0] CONSOLE_TX   = 16'h0000;
    localparam logic [15:0] CONSOLE_STAT = 16'h0004;
    localparam logic [15:0] MTIME_LO     = 16'h0008;
    localparam logic [15:0] MTIME_HI     = 16'h000C;
    localparam logic [15:0] MTIMECMP_LO  = 16'h0010;
    localparam logic [15:0] MTIMECMP_HI  = 16'h0014;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_RAM,
        RD_MMIO
    } rd_sel_e;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO, zero-latency head; push while full is accepted only if a pop happens the same cycle.
// Rejected pushes are flagged on drop_o; head reads 0 when empty.
module console_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic             drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/bus_mmio_responder.sv
// Data-bus responder: RAM + MMIO (console FIFO, optional timer under MMIO_TIMER_EN); read latency 1, writes visible next cycle.
// No bus backpressure; console drains on console_valid && console_ready, pushes into a full FIFO are dropped and flagged.
module bus_mmio_responder
    import bus_mmio_pkg::*;
#(
    parameter int          RAM_WORDS  = 4096,
    parameter logic [31:0] RAM_BASE   = 32'h0001_0000,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready,
    output logic        timer_irq
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    logic              ram_hit, mmio_hit, mmio_wr;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       mmio_off;
    logic [1:0]        unused_addr_lsb;

    assign ram_hit         = (bus_address[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
    assign mmio_hit        = (bus_address[31:16] == MMIO_BASE[31:16]);
    assign ram_idx         = bus_address[RAM_AW+1:2];
    assign mmio_off        = {bus_address[15:2], 2'b00};
    assign mmio_wr         = bus_write_enable && mmio_hit;
    assign unused_addr_lsb = bus_address[1:0];

    // RAM is uninitialised storage; its read port is gated by rd_sel_q so reset still yields 0.
    logic [31:0] ram_q [RAM_WORDS];
    logic [31:0] ram_rd_q;

    always_ff @(posedge clock) begin
        if (bus_write_enable && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_byte_enable[i]) ram_q[ram_idx][8*i +: 8] <= bus_write_data[8*i +: 8];
            end
        end
        if (bus_read_enable && ram_hit) ram_rd_q <= ram_q[ram_idx];
    end

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;
    logic          ovf_q, ovf_d;

    assign fifo_push     = mmio_wr && (mmio_off == CONSOLE_TX) && bus_byte_enable[0];
    assign fifo_pop      = console_valid && console_ready;
    assign console_valid = !fifo_empty;

    console_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_console_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (fifo_push),
        .push_dat_i (bus_write_data[7:0]),
        .pop_i      (fifo_pop),
        .head_o     (console_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .drop_o     (fifo_drop)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (mmio_wr && (mmio_off == CONSOLE_STAT) && bus_byte_enable[0]
                     && bus_write_data[STAT_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic        irq_q;

    // A write to either mtime half replaces the tick for that cycle.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (mmio_wr) begin
            case (mmio_off)
                MTIME_LO:    mtime_d    = {mtime_q[63:32], lane_merge(mtime_q[31:0], bus_write_data, bus_byte_enable)};
                MTIME_HI:    mtime_d    = {lane_merge(mtime_q[63:32], bus_write_data, bus_byte_enable), mtime_q[31:0]};
                MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], lane_merge(mtimecmp_q[31:0], bus_write_data, bus_byte_enable)};
                MTIMECMP_HI: mtimecmp_d = {lane_merge(mtimecmp_q[63:32], bus_write_data, bus_byte_enable), mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_irq = irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    rd_sel_e     rd_sel_q, rd_sel_d;
    logic [31:0] mmio_rd_q, mmio_rd_d;

    always_comb begin
        rd_sel_d = ram_hit ? RD_RAM : (mmio_hit ? RD_MMIO : RD_NONE);
        mmio_rd_d = '0;
        case (mmio_off)
            CONSOLE_STAT: begin
                mmio_rd_d[STAT_FULL_BIT]         = fifo_full;
                mmio_rd_d[STAT_EMPTY_BIT]        = fifo_empty;
                mmio_rd_d[STAT_OVF_BIT]          = ovf_q;
                mmio_rd_d[STAT_COUNT_LSB +: 8]   = 8'(fifo_count);
            end
`ifdef MMIO_TIMER_EN
            MTIME_LO:    mmio_rd_d = mtime_q[31:0];
            MTIME_HI:    mmio_rd_d = mtime_q[63:32];
            MTIMECMP_LO: mmio_rd_d = mtimecmp_q[31:0];
            MTIMECMP_HI: mmio_rd_d = mtimecmp_q[63:32];
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_sel_q  <= RD_NONE;
            mmio_rd_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (bus_read_enable) begin
                rd_sel_q  <= rd_sel_d;
                mmio_rd_q <= mmio_rd_d;
            end
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        case (rd_sel_q)
            RD_RAM:  bus_read_data = ram_rd_q;
            RD_MMIO: bus_read_data = mmio_rd_q;
            default: bus_read_data = '0;
        endcase
    end

endmodule
